upg_frame_loader: RTL
=====================

Name: upg_frame_loader

Overview:
- Parametrised successor to the fixed UART programmer path: consumes a received byte stream, parses framed load records, and emits word writes to one of BANKS target memories (instruction ROM, data RAM, ...).
- Adds the following: per-frame start address, 8-bit checksum, an inter-byte timeout, and an explicit end-of-load frame.
- Sits between the UART byte receiver and the memory programming ports. The CPU reset is held while done=0.

Parameters:
- WORD_BYTES, 4: bytes per memory word; DATA_W = 8*WORD_BYTES.
- ADDR_W, 14: word-address width of the write port.
- BANKS, 2: number of target memories; BANK_W = max(1, clog2(BANKS)).
- TIMEOUT_CYC, 100000: maximum idle clock cycles between bytes inside a frame.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-low.
- rx_valid, in, 1: one-cycle strobe, rx_data valid; no backpressure.
- rx_data, in, 8: received byte.
- wr_en, out, 1: one-cycle write strobe.
- wr_bank, out, BANK_W: target memory index.
- wr_addr, out, ADDR_W: word address.
- wr_data, out, DATA_W: assembled word, little-endian.
- frame_ok, out, 1: one-cycle pulse, frame checksum good.
- frame_err, out, 1: one-cycle pulse, frame aborted or bad.
- err_code, out, 2: 01 checksum, 10 bad bank, 11 timeout; held until next frame_ok/frame_err.
- done, out, 1: end-of-load received; sticky until reset.

Behaviour:
- Reset (reset=0 at a clock edge): all outputs 0, state IDLE, counters and checksum cleared. Reset mid-frame discards the partial frame and produces no write.
- Frame format: A5, BANK, ADDR_H, ADDR_L, LEN, LEN*WORD_BYTES data bytes, CSUM.
- Checksum: the 8-bit sum of BANK..CSUM inclusive must be 0x00 mod 256. A5 is excluded.
- States and transitions:
  - IDLE: byte == A5 goes to BANK; any other byte is ignored.
  - BANK: byte == FF goes to DONE. byte >= BANKS goes to IDLE with frame_err and err_code=10. Otherwise latch the bank and go to ADDR_H.
  - ADDR_H, then ADDR_L: latch {ADDR_H,ADDR_L}[ADDR_W-1:0]; upper bits are dropped.
  - LEN: LEN=0 goes directly to CSUM; otherwise go to DATA.
  - DATA: shift bytes into the word, first byte into bits [7:0]. When byte WORD_BYTES-1 is accepted:
    - the next cycle, wr_en=1 with the current address and data;
    - the address increments mod 2^ADDR_W (wrap 2^ADDR_W-1 to 0);
    - after LEN words, go to CSUM.
  - CSUM: the cycle after the byte, pulse frame_ok if the sum is 0, else frame_err with err_code=01. Return to IDLE.
  - DONE: done=1, all bytes ignored, no writes until reset.
- Writes are not retracted on a checksum error; the error is reported only.
- Timeout:
  - The counter runs only in BANK..CSUM and clears on every accepted byte.
  - Reaching TIMEOUT_CYC gives frame_err with err_code=11 and returns to IDLE; a partial word is not written.
  - A byte arriving in the same cycle the count expires wins: the byte is accepted and the counter is cleared.
- wr_en and frame_ok/frame_err never assert in the same cycle.
- Throughput: a byte can be accepted every cycle. At most one write per WORD_BYTES bytes.

Decomposition:
- Shared package upg_pkg:
  - state enum (IDLE, BANK, ADDR_H, ADDR_L, LEN, DATA, CSUM, DONE);
  - SYNC_BYTE=8'hA5, END_BANK=8'hFF;
  - error codes ERR_CSUM=2'b01, ERR_BANK=2'b10, ERR_TMO=2'b11.
- One sub-module, upg_word_packer: byte shift register plus byte counter. Outputs word_ready and word; inputs clear and load.

Test Plan:
- Normal write: BANKS=2, send A5 00 00 10 01 78 56 34 12 DB. Expect wr_en once, bank 0, addr 0x0010, data 0x12345678, then frame_ok=1 the next cycle after CSUM.
- Bad checksum: same frame with CSUM DC. Expect the same write, then frame_err=1, err_code=01.
- Bad bank and recovery: send A5 05. Expect frame_err, err_code=10, no write. A following valid frame to bank 1 writes with wr_bank=1.
- Timeout: TIMEOUT_CYC=16, send A5 01 00, then silence. Expect frame_err, err_code=11 at the 16th idle cycle, no write. Also check that a byte arriving on the expiry cycle keeps the frame alive.
- Address wrap with back-to-back bytes: ADDR_W=14, start 0x3FFF, LEN=2, bytes on consecutive cycles. Expect writes at 0x3FFF, then 0x0000, with the correct data.
- End of load and reset: send A5 FF. Expect done=1. Further bytes cause no writes. reset=0 for 1 cycle clears done. Reset asserted mid-DATA produces no write and returns to IDLE.

Source files
------------

// File: rtl/upg_frame_loader_pkg.sv
// upg_pkg: parser states, framing bytes and error codes shared by the frame loader.
package upg_pkg;
  typedef enum logic [2:0] {IDLE, BANK, ADDR_H, ADDR_L, LEN, DATA, CSUM, DONE} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_BANK = 8'hFF;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_BANK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;
  function automatic int min_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/upg_frame_loader_if.sv
// upg_frame_loader_if: received byte stream in, memory write port and load status out.
interface upg_frame_loader_if #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W = 14,
  parameter int BANKS = 2
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BANK_W = upg_pkg::min_width(BANKS);
  logic rx_valid;
  logic [7:0] rx_data;
  logic wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic frame_ok;
  logic frame_err;
  logic [1:0] err_code;
  logic done;
  modport master (output rx_valid, rx_data,
                  input wr_en, wr_bank, wr_addr, wr_data, frame_ok, frame_err, err_code, done);
  modport slave (input rx_valid, rx_data,
                 output wr_en, wr_bank, wr_addr, wr_data, frame_ok, frame_err, err_code, done);
endinterface

// File: rtl/upg_frame_loader_word_packer.sv
// upg_word_packer: assembles little-endian words from bytes; word/word_ready show the word completed by this byte.
module upg_word_packer #(
  parameter int WORD_BYTES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic [7:0] data,
  output logic word_ready,
  output logic [8*WORD_BYTES-1:0] word
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int CNT_W = upg_pkg::min_width(WORD_BYTES);
  logic [CNT_W-1:0] cnt;
  assign word_ready = load && cnt == CNT_W'(WORD_BYTES - 1);
  if (WORD_BYTES > 1) begin : g_shift
    logic [DATA_W-9:0] sr;
    assign word = {data, sr};
    always_ff @(posedge clock)
      sr <= (!reset || clear) ? '0 : load ? word[DATA_W-1:8] : sr;
  end else begin : g_single
    assign word = data;
  end
  always_ff @(posedge clock)
    cnt <= (!reset || clear || word_ready) ? '0 : load ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/upg_frame_loader.sv
// upg_frame_loader: parses A5-framed load records from a byte stream into bank/word writes,
// with checksum, inter-byte timeout and a sticky end-of-load flag.
module upg_frame_loader import upg_pkg::*; #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W = 14,
  parameter int BANKS = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clock,
  input logic reset,
  upg_frame_loader_if.slave bus
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BANK_W = min_width(BANKS);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  state_t st;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] addr;
  logic [7:0] addr_h, sum, words_left;
  logic [TMO_W-1:0] tcnt;
  logic in_frame, expired, word_ready;
  logic [DATA_W-1:0] word;
  assign in_frame = st != IDLE && st != DONE;
  // an arriving byte on the last allowed cycle keeps the frame alive
  assign expired = in_frame && !bus.rx_valid && tcnt == TMO_W'(TIMEOUT_CYC - 1);
  upg_word_packer #(.WORD_BYTES(WORD_BYTES)) packer (
    .clock(clock),
    .reset(reset),
    .clear(st != DATA),
    .load(bus.rx_valid && st == DATA),
    .data(bus.rx_data),
    .word_ready(word_ready),
    .word(word)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      st <= IDLE;
      bank <= '0;
      addr <= '0;
      addr_h <= '0;
      sum <= '0;
      words_left <= '0;
      tcnt <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_bank <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.frame_ok <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_code <= 2'b00;
      bus.done <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.frame_ok <= 1'b0;
      bus.frame_err <= 1'b0;
      tcnt <= (bus.rx_valid || !in_frame) ? '0 : tcnt + 1'b1;
      if (expired) begin
        st <= IDLE;
        bus.frame_err <= 1'b1;
        bus.err_code <= ERR_TMO;
      end else if (bus.rx_valid) begin
        case (st)
          IDLE: st <= bus.rx_data == SYNC_BYTE ? BANK : IDLE;
          BANK: begin
            if (bus.rx_data == END_BANK) begin
              st <= DONE;
              bus.done <= 1'b1;
            end else if (32'(bus.rx_data) >= BANKS) begin
              st <= IDLE;
              bus.frame_err <= 1'b1;
              bus.err_code <= ERR_BANK;
            end else begin
              st <= ADDR_H;
              bank <= bus.rx_data[BANK_W-1:0];
              sum <= bus.rx_data;
            end
          end
          ADDR_H: begin
            st <= ADDR_L;
            addr_h <= bus.rx_data;
            sum <= sum + bus.rx_data;
          end
          ADDR_L: begin
            st <= LEN;
            addr <= ADDR_W'({addr_h, bus.rx_data});
            sum <= sum + bus.rx_data;
          end
          LEN: begin
            st <= bus.rx_data == 8'd0 ? CSUM : DATA;
            words_left <= bus.rx_data;
            sum <= sum + bus.rx_data;
          end
          DATA: begin
            sum <= sum + bus.rx_data;
            if (word_ready) begin
              bus.wr_en <= 1'b1;
              bus.wr_bank <= bank;
              bus.wr_addr <= addr;
              bus.wr_data <= word;
              addr <= addr + 1'b1;
              words_left <= words_left - 1'b1;
              st <= words_left == 8'd1 ? CSUM : DATA;
            end
          end
          CSUM: begin
            st <= IDLE;
            bus.frame_ok <= 8'(sum + bus.rx_data) == 8'd0;
            bus.frame_err <= 8'(sum + bus.rx_data) != 8'd0;
            bus.err_code <= 8'(sum + bus.rx_data) == 8'd0 ? 2'b00 : ERR_CSUM;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
